// File: rtl/ldpc_ber_sweep_ctrl.sv
// Purpose : SNR-sweep sequencer; per point programs AWGN factor/offset, soft-resets the
//           datapath, runs until a block/error stop condition, drains, emits one record.
// Latency : RESET_CYCLES reset + >=2 run + DRAIN_CYCLES drain cycles per point, then REPORT.
// Backpressure: the record is held stable in REPORT until res_ready; the sweep stalls meanwhile.
// Ports   : data_clk/data_rst (async, active-high); start/abort control; cfg_* sweep setup
//           (latched on start); data_* counters in / controls out; busy/done status;
//           res_* valid/ready result record.
module ldpc_ber_sweep_ctrl #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES = 64,
  parameter int unsigned PT_W         = 8
) (
  input  logic            data_clk,
  input  logic            data_rst,
  input  logic            start,
  input  logic            abort,
  input  logic [PT_W-1:0] cfg_num_points,
  input  logic [15:0]     cfg_factor_start,
  input  logic [15:0]     cfg_factor_step,
  input  logic [7:0]      cfg_offset,
  input  logic [63:0]     cfg_min_blocks,
  input  logic [63:0]     cfg_max_errors,
  input  logic [63:0]     data_finished_blocks,
  input  logic [63:0]     data_bit_errors,
  output logic            data_en,
  output logic            data_sw_resetn,
  output logic [15:0]     data_factor,
  output logic [7:0]      data_offset,
  output logic            busy,
  output logic            done,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [PT_W-1:0] res_point,
  output logic [15:0]     res_factor,
  output logic [63:0]     res_blocks,
  output logic [63:0]     res_errors
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_RUN, S_DRAIN, S_REPORT, S_DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              first_run_q;
  logic [PT_W-1:0]   point_q;
  logic [PT_W-1:0]   num_points_q;
  logic [15:0]       step_q;
  logic [63:0]       min_blocks_q;
  logic [63:0]       max_errors_q;

  logic              data_en_q, data_sw_resetn_q, busy_q, done_q, res_valid_q;
  logic [15:0]       data_factor_q, res_factor_q;
  logic [7:0]        data_offset_q;
  logic [PT_W-1:0]   res_point_q;
  logic [63:0]       res_blocks_q, res_errors_q;

  logic              stop_d;
  logic [16:0]       fac_sum_d;

  // Stop when the block target is met (a zero count never qualifies, so a target of 0
  // means "first block"), or when the optional error cap is reached.
  assign stop_d = ((data_finished_blocks >= min_blocks_q) && (data_finished_blocks != 64'd0)) ||
                  ((max_errors_q != 64'd0) && (data_bit_errors >= max_errors_q));

  // Carry out of the 17-bit sum means the factor clamps at full scale.
  assign fac_sum_d = {1'b0, data_factor_q} + {1'b0, step_q};

  always_ff @(posedge data_clk or posedge data_rst) begin
    if (data_rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      first_run_q      <= 1'b0;
      point_q          <= '0;
      num_points_q     <= '0;
      step_q           <= '0;
      min_blocks_q     <= '0;
      max_errors_q     <= '0;
      data_en_q        <= 1'b0;
      data_sw_resetn_q <= 1'b1;
      data_factor_q    <= '0;
      data_offset_q    <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      res_valid_q      <= 1'b0;
      res_point_q      <= '0;
      res_factor_q     <= '0;
      res_blocks_q     <= '0;
      res_errors_q     <= '0;
    end else if (abort) begin
      // Factor/offset are left as they were so the aborted point stays visible.
      state_q          <= S_IDLE;
      data_en_q        <= 1'b0;
      data_sw_resetn_q <= 1'b1;
      res_valid_q      <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      first_run_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            num_points_q <= cfg_num_points;
            step_q       <= cfg_factor_step;
            min_blocks_q <= cfg_min_blocks;
            max_errors_q <= cfg_max_errors;
            if (cfg_num_points == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              point_q          <= '0;
              data_factor_q    <= cfg_factor_start;
              data_offset_q    <= cfg_offset;
              done_q           <= 1'b0;
              busy_q           <= 1'b1;
              data_sw_resetn_q <= 1'b0;
              data_en_q        <= 1'b0;
              cnt_q            <= CNT_W'(RESET_CYCLES - 1);
              state_q          <= S_RST;
            end
          end
        end
        S_RST: begin
          if (cnt_q == '0) begin
            data_sw_resetn_q <= 1'b1;
            data_en_q        <= 1'b1;
            first_run_q      <= 1'b1;
            state_q          <= S_RUN;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RUN: begin
          // Counters can still show stale pre-reset values on the first RUN cycle.
          first_run_q <= 1'b0;
          if (!first_run_q && stop_d) begin
            data_en_q <= 1'b0;
            cnt_q     <= CNT_W'(DRAIN_CYCLES - 1);
            state_q   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cnt_q == '0) begin
            res_blocks_q <= data_finished_blocks;
            res_errors_q <= data_bit_errors;
            res_point_q  <= point_q;
            res_factor_q <= data_factor_q;
            res_valid_q  <= 1'b1;
            state_q      <= S_REPORT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (point_q == num_points_q - PT_W'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              point_q          <= point_q + PT_W'(1);
              data_factor_q    <= fac_sum_d[16] ? 16'hFFFF : fac_sum_d[15:0];
              data_sw_resetn_q <= 1'b0;
              cnt_q            <= CNT_W'(RESET_CYCLES - 1);
              state_q          <= S_RST;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_en        = data_en_q;
  assign data_sw_resetn = data_sw_resetn_q;
  assign data_factor    = data_factor_q;
  assign data_offset    = data_offset_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign res_valid      = res_valid_q;
  assign res_point      = res_point_q;
  assign res_factor     = res_factor_q;
  assign res_blocks     = res_blocks_q;
  assign res_errors     = res_errors_q;

endmodule

// File: tb/tb_ldpc_ber_sweep_ctrl.sv
// Bench for the sweep sequencer: a counting datapath model, a record-level expectation
// queue, and one negedge compare process checking protocol rules and records.
module tb_ldpc_ber_sweep_ctrl;

  localparam int RC = 4;
  localparam int DC = 8;
  localparam int PW = 8;

  logic          data_clk = 1'b0;
  logic          data_rst, start, abort, res_ready;
  logic [PW-1:0] cfg_num_points;
  logic [15:0]   cfg_factor_start, cfg_factor_step;
  logic [7:0]    cfg_offset;
  logic [63:0]   cfg_min_blocks, cfg_max_errors;
  logic [63:0]   dp_blk, dp_err, binc, einc;
  logic          data_en, data_sw_resetn, busy, done, res_valid;
  logic [15:0]   data_factor, res_factor;
  logic [7:0]    data_offset;
  logic [PW-1:0] res_point;
  logic [63:0]   res_blocks, res_errors;

  always #5 data_clk = ~data_clk;

  ldpc_ber_sweep_ctrl #(.RESET_CYCLES(RC), .DRAIN_CYCLES(DC), .PT_W(PW)) dut (
    .data_clk(data_clk), .data_rst(data_rst), .start(start), .abort(abort),
    .cfg_num_points(cfg_num_points), .cfg_factor_start(cfg_factor_start),
    .cfg_factor_step(cfg_factor_step), .cfg_offset(cfg_offset),
    .cfg_min_blocks(cfg_min_blocks), .cfg_max_errors(cfg_max_errors),
    .data_finished_blocks(dp_blk), .data_bit_errors(dp_err),
    .data_en(data_en), .data_sw_resetn(data_sw_resetn), .data_factor(data_factor),
    .data_offset(data_offset), .busy(busy), .done(done), .res_valid(res_valid),
    .res_ready(res_ready), .res_point(res_point), .res_factor(res_factor),
    .res_blocks(res_blocks), .res_errors(res_errors)
  );

  // Datapath stand-in: counters clear under soft reset and advance while enabled.
  always @(posedge data_clk or posedge data_rst) begin
    if (data_rst) begin
      dp_blk <= '0;
      dp_err <= '0;
    end else if (!data_sw_resetn) begin
      dp_blk <= '0;
      dp_err <= '0;
    end else if (data_en) begin
      dp_blk <= dp_blk + binc;
      dp_err <= dp_err + einc;
    end
  end

  typedef struct {
    logic [PW-1:0] point;
    logic [15:0]   factor;
    logic [63:0]   blocks;
    logic [63:0]   errors;
    logic          last;
  } rec_t;

  rec_t        exp_q[$];
  logic [15:0] got_fac[$];
  logic [63:0] got_blk[$];
  logic [63:0] got_err[$];
  logic [7:0]  exp_offset;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_resets = 0;
  int          n_rec    = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Factor of point p: start + p*step, clamped to full scale.
  function automatic logic [15:0] exp_fac(input int unsigned fs, input int unsigned st, input int p);
    longint v;
    v = longint'(fs) + longint'(st) * longint'(p);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  // Number of counted RUN cycles until the stop rule holds; one more increment lands
  // on the edge that drops data_en, so captured values are (j+1)*increment.
  function automatic int stop_j(input logic [63:0] minb, input logic [63:0] maxe,
                                input logic [63:0] bi, input logic [63:0] ei);
    for (int j = 1; j < 100000; j++) begin
      logic [63:0] b, e;
      b = 64'(j) * bi;
      e = 64'(j) * ei;
      if ((b >= minb && b != 0) || (maxe != 0 && e >= maxe)) return j;
    end
    return 100000;
  endfunction

  // ---------------- compare process ----------------
  logic          prev_resetn = 1'b1, prev_en = 1'b0, prev_valid = 1'b0;
  logic          prev_hs = 1'b0, prev_last = 1'b0, drain_act = 1'b0;
  int            low_run = 0, drain_cnt = 0;
  logic [151:0]  prev_fields = '0;

  always @(negedge data_clk) begin
    logic         hs;
    logic [151:0] cur;
    rec_t         e;
    if (data_rst) begin
      prev_resetn = 1'b1; prev_en = 1'b0; prev_valid = 1'b0;
      prev_hs = 1'b0; prev_last = 1'b0; low_run = 0; drain_act = 1'b0;
    end else begin
      cur = {res_point, res_factor, res_blocks, res_errors};
      check("en_during_swreset", data_en && !data_sw_resetn, 0);
      check("busy_done_exclusive", busy && done, 0);
      if (busy) check("offset", data_offset, exp_offset);
      if (prev_hs) begin
        if (prev_last) begin
          check("done_after_last", done, 1);
          check("idle_after_last", busy, 0);
        end else begin
          check("swreset_after_hs", data_sw_resetn, 0);
        end
      end
      if (!data_sw_resetn) low_run++;
      else if (!prev_resetn) begin
        check("swreset_len", low_run, RC);
        check("en_with_release", data_en, 1);
        low_run = 0;
        n_resets++;
      end
      if (!busy) drain_act = 1'b0;
      else if (prev_en && !data_en) begin
        drain_act = 1'b1;
        drain_cnt = 1;
      end else if (res_valid && !prev_valid) begin
        check("drain_len", drain_act ? drain_cnt : 0, DC);
        drain_act = 1'b0;
      end else if (drain_act) drain_cnt++;
      if (res_valid) check("quiet_in_report", {data_sw_resetn, data_en}, 2'b10);
      if (res_valid && prev_valid && !prev_hs) check("res_stable", cur == prev_fields, 1);
      hs = res_valid && res_ready;
      prev_last = 1'b0;
      if (hs) begin
        if (exp_q.size() == 0) check("unexpected_record", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("res_point", res_point, e.point);
          check("res_factor", res_factor, e.factor);
          check("res_blocks", res_blocks, e.blocks);
          check("res_errors", res_errors, e.errors);
          prev_last = e.last;
        end
        got_fac.push_back(res_factor);
        got_blk.push_back(res_blocks);
        got_err.push_back(res_errors);
        n_rec++;
      end
      prev_resetn = data_sw_resetn;
      prev_en     = data_en;
      prev_valid  = res_valid;
      prev_hs     = hs;
      prev_fields = cur;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge data_clk);
      #1;
    end
  endtask

  task automatic clear_got();
    got_fac.delete(); got_blk.delete(); got_err.delete();
  endtask

  task automatic start_sweep(input int np, input int unsigned fs, input int unsigned st,
                             input logic [7:0] off, input logic [63:0] minb,
                             input logic [63:0] maxe, input logic [63:0] bi,
                             input logic [63:0] ei);
    int j;
    rec_t r;
    cfg_num_points = PW'(np); cfg_factor_start = 16'(fs); cfg_factor_step = 16'(st);
    cfg_offset = off; cfg_min_blocks = minb; cfg_max_errors = maxe;
    binc = bi; einc = ei; exp_offset = off;
    j = stop_j(minb, maxe, bi, ei);
    for (int p = 0; p < np; p++) begin
      r.point  = PW'(p);
      r.factor = exp_fac(fs, st, p);
      r.blocks = 64'(j + 1) * bi;
      r.errors = 64'(j + 1) * ei;
      r.last   = (p == np - 1);
      exp_q.push_back(r);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    // Scramble config: a running sweep must keep using its latched copy.
    cfg_num_points = 1; cfg_factor_start = 16'h1234; cfg_factor_step = 16'h7;
    cfg_offset = 8'h5A; cfg_min_blocks = 2; cfg_max_errors = 1;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int i = 0;
    while (!done && i < budget) begin tick(1); i++; end
    check({nm, "_done_reached"}, done, 1);
  endtask

  task automatic wait_en(input int budget);
    int i = 0;
    while (!data_en && i < budget) begin tick(1); i++; end
    check("wait_data_en", data_en, 1);
  endtask

  initial begin
    int r0, k0, i;
    data_rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    cfg_num_points = '0; cfg_factor_start = '0; cfg_factor_step = '0; cfg_offset = '0;
    cfg_min_blocks = '0; cfg_max_errors = '0; binc = 1; einc = 0; exp_offset = '0;
    #3;
    check("rst_state", {data_en, data_sw_resetn, busy, done, res_valid}, 5'b01000);
    check("rst_factor_offset", {data_factor, data_offset}, 0);
    check("rst_res_fields", (res_point == 0) && (res_factor == 0) && (res_blocks == 0) && (res_errors == 0), 1);
    tick(2);
    data_rst = 1'b0;
    tick(2);

    // 3-point sweep, blocks +1/cycle, with an ignored start while busy.
    clear_got(); r0 = n_resets;
    start_sweep(3, 100, 50, 8'h33, 10, 0, 1, 0);
    tick(20);
    start = 1'b1; tick(1); start = 1'b0;
    check("start_while_busy", busy, 1);
    wait_done(2000, "sweep3");
    check("sweep3_nrec", got_fac.size(), 3);
    check("sweep3_resets", n_resets - r0, 3);
    if (got_fac.size() == 3) begin
      check("sweep3_f0", got_fac[0], 100);
      check("sweep3_f1", got_fac[1], 150);
      check("sweep3_f2", got_fac[2], 200);
      check("sweep3_b0", got_blk[0], 11);
    end

    // Factor saturation.
    clear_got();
    start_sweep(3, 16'hFFF0, 16'h0010, 8'h01, 3, 0, 1, 0);
    wait_done(2000, "sat");
    check("sat_nrec", got_fac.size(), 3);
    if (got_fac.size() == 3) begin
      check("sat_f0", got_fac[0], 16'hFFF0);
      check("sat_f1", got_fac[1], 16'hFFFF);
      check("sat_f2", got_fac[2], 16'hFFFF);
    end

    // Error cap stops long before the block target.
    clear_got();
    start_sweep(1, 16'h10, 1, 8'h02, 1000, 5, 1, 1);
    wait_done(2000, "errcap");
    if (got_err.size() == 1) begin
      check("errcap_errors", got_err[0], 6);
      check("errcap_blocks", got_blk[0], 6);
    end else check("errcap_nrec", got_err.size(), 1);

    // Both stop terms true on the same cycle -> one record.
    clear_got();
    start_sweep(1, 16'h20, 1, 8'h03, 5, 5, 1, 1);
    wait_done(2000, "both");
    check("both_nrec", got_blk.size(), 1);

    // Block target 0 stops on the first block.
    clear_got();
    start_sweep(1, 16'h30, 1, 8'h04, 0, 0, 1, 0);
    wait_done(2000, "minb0");
    if (got_blk.size() == 1) check("minb0_blocks", got_blk[0], 2);
    else check("minb0_nrec", got_blk.size(), 1);

    // Backpressure: consumer stalls 20 cycles on the first record.
    clear_got(); res_ready = 1'b0;
    start_sweep(2, 500, 1, 8'h05, 4, 0, 1, 0);
    i = 0;
    while (!res_valid && i < 500) begin tick(1); i++; end
    check("bp_valid_seen", res_valid, 1);
    r0 = n_resets; k0 = n_rec;
    tick(20);
    check("bp_valid_held", res_valid, 1);
    check("bp_no_rst", n_resets - r0, 0);
    check("bp_no_rec", n_rec - k0, 0);
    res_ready = 1'b1;
    wait_done(2000, "bp");
    check("bp_nrec", got_fac.size(), 2);

    // Abort during RUN of point 1, with a simultaneous (ignored) start.
    clear_got(); k0 = n_rec;
    start_sweep(3, 100, 50, 8'h06, 10, 0, 1, 0);
    i = 0;
    while (n_rec == k0 && i < 500) begin tick(1); i++; end
    check("abort_first_rec", n_rec - k0, 1);
    wait_en(100);
    tick(3);
    abort = 1'b1; start = 1'b1;
    tick(1);
    abort = 1'b0; start = 1'b0;
    check("abort_state", {busy, done, data_en, data_sw_resetn, res_valid}, 5'b00010);
    check("abort_factor_held", data_factor, 150);
    check("abort_pending", exp_q.size(), 2);
    exp_q.delete();
    k0 = n_rec;
    tick(40);
    check("abort_no_more_rec", n_rec - k0, 0);
    check("abort_stays_idle", busy, 0);
    clear_got();
    start_sweep(3, 100, 50, 8'h07, 10, 0, 1, 0);
    wait_done(2000, "restart");
    check("restart_nrec", got_fac.size(), 3);
    if (got_fac.size() == 3) check("restart_f0", got_fac[0], 100);

    // Zero-point sweep: done next cycle, no reset pulse, no record.
    abort = 1'b1; tick(1); abort = 1'b0;
    check("pre_zero_done_clear", done, 0);
    r0 = n_resets; k0 = n_rec;
    start_sweep(0, 1, 1, 8'h08, 1, 0, 1, 0);
    check("zero_done", {done, busy}, 2'b10);
    tick(20);
    check("zero_no_rst", n_resets - r0, 0);
    check("zero_no_rec", n_rec - k0, 0);

    // Asynchronous reset mid-sweep.
    start_sweep(2, 700, 1, 8'h09, 10, 0, 1, 0);
    wait_en(100);
    #2 data_rst = 1'b1;
    #1;
    check("arst_state", {data_en, data_sw_resetn, busy, done, res_valid}, 5'b01000);
    check("arst_factor_offset", {data_factor, data_offset}, 0);
    exp_q.delete();
    tick(2);
    data_rst = 1'b0;
    tick(2);
    check("arst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
